// File: rtl/uart_pkg.sv
// Shared UART constants: line framing plus receive-buffer defaults.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_STOP_BITS  = 1;

    localparam int UART_RX_FIFO_DEPTH = 16;
    localparam int UART_RX_FIFO_DW    = UART_DATA_BITS;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: first-word fall-through FIFO with
// level threshold interrupt and sticky overflow flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH,
    parameter int DW    = UART_RX_FIFO_DW
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [DW-1:0]            rx_data_i,
    input  logic                     rx_done_i,
    input  logic                     fifo_en_i,
    input  logic                     clr_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH):0]   thresh_i,
    input  logic                     ovf_clr_i,
    output logic [DW-1:0]            rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     thresh_irq_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_overflow;

    logic [PW-1:0] w_level;
    logic          w_empty;
    logic          w_full;
    logic          w_strobe;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign w_level  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (w_level == '0);
    assign w_full   = (w_level == DEPTH_L);
    assign w_strobe = rx_done_i & fifo_en_i;
    assign w_pop    = rd_en_i & ~w_empty;
    assign w_push   = w_strobe & (~w_full | w_pop);
    assign w_drop   = w_strobe & w_full & ~w_pop;

    always_ff @(posedge clk_i) begin
        if (w_push && !clr_i) begin
            r_mem[r_wr_ptr[AW-1:0]] <= rx_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (clr_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // A drop in the same cycle as a clear request keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr_i) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rd_data_o    = r_mem[r_rd_ptr[AW-1:0]];
    assign empty_o      = w_empty;
    assign full_o       = w_full;
    assign level_o      = w_level;
    assign overflow_o   = r_overflow;
    assign thresh_irq_o = (thresh_i != '0) && (w_level >= thresh_i);

endmodule
